// File: rtl/fsm_sym_feeder_if.sv
// Byte-in / symbol-out bundle for fsm_sym_feeder.
// Valid/ready: a byte moves on a rising edge only where in_valid && in_ready are both high.
interface fsm_sym_feeder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        en;
    logic [1:0]  ptext;
    logic        ptext_valid;
    logic [15:0] sym_cnt;

    modport master (
        output in_data, in_valid, flush, en,
        input  in_ready, ptext, ptext_valid, sym_cnt
    );

    modport slave (
        input  in_data, in_valid, flush, en,
        output in_ready, ptext, ptext_valid, sym_cnt
    );
endinterface

// File: rtl/fsm_sym_feeder.sv
// Byte FIFO feeding a 2-bit symbol shifter; each accepted byte leaves as four symbols.
// state_dbg exposes the shifter state (0 = EMPTY, 1 = LOADED).
module fsm_sym_feeder #(
    parameter int          DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b0,
    parameter logic [1:0]  IDLE_SYM  = 2'b00
) (
    input  logic             CLK,
    input  logic             RST,
    fsm_sym_feeder_if.slave  bus,
    output logic             state_dbg
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cur_q, cur_d;
    logic [1:0]      idx_q, idx_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     sym_cnt_q, sym_cnt_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            in_ready;
    logic            push;
    logic            pop;
    logic [7:0]      shifted;
    logic [1:0]      sym;

    // Readiness comes from registered occupancy only, so a pop this cycle never frees space early.
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_ready = !full && !bus.flush;
    assign push     = bus.in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        sym_cnt_d = sym_cnt_q;
        pop       = 1'b0;

        if (bus.flush) begin
            state_d  = S_EMPTY;
            idx_d    = 2'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        cur_d   = mem_q[rd_ptr_q];
                        idx_d   = 2'd0;
                        state_d = S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (bus.en) begin
                        sym_cnt_d = sym_cnt_q + 16'd1;
                        if (idx_q != 2'd3) begin
                            idx_d = idx_q + 2'd1;
                        end else if (!empty) begin
                            // Reload on the last symbol so consecutive bytes stream without a bubble.
                            pop   = 1'b1;
                            cur_d = mem_q[rd_ptr_q];
                            idx_d = 2'd0;
                        end else begin
                            idx_d   = 2'd0;
                            state_d = S_EMPTY;
                        end
                    end
                end
                default: state_d = S_EMPTY;
            endcase

            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        shifted = 8'h00;
        sym     = 2'b00;
        if (MSB_FIRST) begin
            shifted = cur_q << {idx_q, 1'b0};
            sym     = shifted[7:6];
        end else begin
            shifted = cur_q >> {idx_q, 1'b0};
            sym     = shifted[1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_EMPTY;
            cur_q     <= 8'h00;
            idx_q     <= 2'd0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            sym_cnt_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is readable.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_ready    = in_ready;
    assign bus.ptext       = (state_q == S_LOADED) ? sym : IDLE_SYM;
    assign bus.ptext_valid = (state_q == S_LOADED);
    assign bus.sym_cnt     = sym_cnt_q;
    assign state_dbg       = (state_q == S_LOADED);
endmodule
